// File: rtl/conv_seq_if.sv
// Host/memory/PE-array signal bundle for the convolution sequencer.
// The master modport is the host side; the slave modport is the sequencer.
interface conv_seq_if #(
  parameter int TAPS   = 3,
  parameter int ADDR_W = 8
);
  localparam int WA_W = $clog2(TAPS);

  logic              start;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic              err;
  logic              w_rd_en;
  logic [WA_W-1:0]   w_addr;
  logic              pe_w_we;
  logic [WA_W-1:0]   pe_w_sel;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_addr;
  logic              pe_en;
  logic              y_valid;
  logic [ADDR_W-1:0] y_index;

  modport master (
    output start, len,
    input  busy, done, err, w_rd_en, w_addr, pe_w_we, pe_w_sel,
    input  x_rd_en, x_addr, pe_en, y_valid, y_index
  );

  modport slave (
    input  start, len,
    output busy, done, err, w_rd_en, w_addr, pe_w_we, pe_w_sel,
    output x_rd_en, x_addr, pe_en, y_valid, y_index
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Job sequencer for a TAPS-long systolic MAC chain: weight load, sample
// streaming with advance enable, result tagging, and host busy/done/err.
module conv_seq_ctrl #(
  parameter int TAPS     = 3,
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  conv_seq_if.slave bus
);
  localparam int WA_W  = $clog2(TAPS);
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [WA_W-1:0]   W_LAST     = WA_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] LEN_MIN    = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] S_MIN      = ADDR_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] s_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q, err_q;
  logic              w_rd_en_q, pe_w_we_q, x_rd_en_q, pe_en_q;
  logic [WA_W-1:0]   w_addr_q, pe_w_sel_q;
  logic [ADDR_W-1:0] x_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      w_rd_en_q  <= 1'b0;
      w_addr_q   <= '0;
      pe_w_we_q  <= 1'b0;
      pe_w_sel_q <= '0;
      x_rd_en_q  <= 1'b0;
      x_addr_q   <= '0;
      pe_en_q    <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len >= LEN_MIN) begin
              state_q   <= LOAD_W;
              busy_q    <= 1'b1;
              len_q     <= bus.len;
              w_rd_en_q <= 1'b1;
              w_addr_q  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD_W: begin
          // PE write strobe trails the weight read by the memory latency
          pe_w_we_q  <= w_rd_en_q;
          pe_w_sel_q <= w_addr_q;
          if (w_rd_en_q) begin
            if (w_addr_q == W_LAST) w_rd_en_q <= 1'b0;
            else                    w_addr_q  <= w_addr_q + WA_W'(1);
          end
          if (pe_w_we_q && pe_w_sel_q == W_LAST) begin
            state_q   <= STREAM;
            x_rd_en_q <= 1'b1;
            x_addr_q  <= '0;
            s_q       <= '0;
          end
        end
        STREAM: begin
          pe_en_q <= x_rd_en_q;
          if (x_rd_en_q) begin
            if (x_addr_q == len_q - ADDR_W'(1)) x_rd_en_q <= 1'b0;
            else                                x_addr_q  <= x_addr_q + ADDR_W'(1);
          end
          if (pe_en_q) s_q <= s_q + ADDR_W'(1);
          if (pe_en_q && !x_rd_en_q) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A pe_en cycle yields a result once the window holds TAPS samples
  logic              res_vld;
  logic [ADDR_W-1:0] res_idx;
  assign res_vld = pe_en_q && (s_q >= S_MIN);
  assign res_idx = s_q - S_MIN;

  // Index stages load only on valid, so the final stage holds its last tag
  for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_lat
    logic              in_vld;
    logic [ADDR_W-1:0] in_idx;
    logic              vld_q;
    logic [ADDR_W-1:0] idx_q;
    if (gi == 0) begin : g_head
      assign in_vld = res_vld;
      assign in_idx = res_idx;
    end else begin : g_tail
      assign in_vld = g_lat[gi-1].vld_q;
      assign in_idx = g_lat[gi-1].idx_q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        idx_q <= '0;
      end else begin
        vld_q <= in_vld;
        if (in_vld) idx_q <= in_idx;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.w_rd_en  = w_rd_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.pe_w_we  = pe_w_we_q;
  assign bus.pe_w_sel = pe_w_sel_q;
  assign bus.x_rd_en  = x_rd_en_q;
  assign bus.x_addr   = x_addr_q;
  assign bus.pe_en    = pe_en_q;
  assign bus.y_valid  = g_lat[PIPE_LAT-1].vld_q;
  assign bus.y_index  = g_lat[PIPE_LAT-1].idx_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: directed scenarios plus random jobs,
// compared every cycle against a job-timeline model indexed by cycle number.
module tb_conv_seq_ctrl;
  localparam int T = 3;
  localparam int A = 8;
  localparam int P = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_seq_if #(.TAPS(T), .ADDR_W(A)) bus ();

  conv_seq_ctrl #(.TAPS(T), .ADDR_W(A), .PIPE_LAT(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: kk = cycle number within the current job (-1 when idle)
  int kk       = -1;
  int len_m    = 0;
  int last_idx = 0;
  bit err_m    = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int job_end(input int l);
    return T + l + P + 3;
  endfunction

  task automatic model_reset();
    kk       = -1;
    last_idx = 0;
    err_m    = 1'b0;
  endtask

  task automatic model_edge(input bit st, input int ln);
    int prev;
    if (rst) begin
      model_reset();
      return;
    end
    prev  = kk;
    err_m = (prev == -1) && st && (ln < T);
    if (prev == -1) begin
      if (st && ln >= T) begin
        kk    = 1;
        len_m = ln;
      end
    end else begin
      kk = prev + 1;
      if (kk > job_end(len_m)) kk = -1;
    end
  endtask

  task automatic check_all();
    int  k;
    int  e;
    bit  yv;
    k  = kk;
    e  = job_end(len_m);
    yv = (k >= 2*T + 2 + P) && (k <= T + 2 + len_m + P) && (k != -1);
    if (yv) last_idx = k - P - 2*T - 2;
    chk("busy",    int'(bus.busy),    int'(k >= 1 && k <= e));
    chk("done",    int'(bus.done),    int'(k == e));
    chk("err",     int'(bus.err),     int'(err_m));
    chk("w_rd_en", int'(bus.w_rd_en), int'(k >= 1 && k <= T));
    if (k >= 1 && k <= T) chk("w_addr", int'(bus.w_addr), k - 1);
    chk("pe_w_we", int'(bus.pe_w_we), int'(k >= 2 && k <= T + 1));
    if (k >= 2 && k <= T + 1) chk("pe_w_sel", int'(bus.pe_w_sel), k - 2);
    chk("x_rd_en", int'(bus.x_rd_en), int'(k >= T + 2 && k <= T + 1 + len_m));
    if (k >= T + 2 && k <= T + 1 + len_m) chk("x_addr", int'(bus.x_addr), k - T - 2);
    chk("pe_en",   int'(bus.pe_en),   int'(k >= T + 3 && k <= T + 2 + len_m));
    chk("y_valid", int'(bus.y_valid), int'(yv));
    chk("y_index", int'(bus.y_index), last_idx);
  endtask

  task automatic step();
    bit st;
    int ln;
    @(posedge clk);
    st = bus.start;
    ln = int'(bus.len);
    model_edge(st, ln);
    #1;
    check_all();
  endtask

  task automatic run_job(input int ln, input int idle_n);
    bus.start = 1'b1;
    bus.len   = A'(ln);
    step();
    bus.start = 1'b0;
    repeat (idle_n) step();
  endtask

  // reset asserted between edges; outputs must clear without a clock
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    bus.start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    run_job(5, 14);
    run_job(3, 12);
    run_job(2, 3);
    run_job(0, 3);

    // extra start in cycle 6 of a running job must be ignored
    run_job(5, 5);
    bus.start = 1'b1;
    bus.len   = A'(7);
    step();
    bus.start = 1'b0;
    repeat (10) step();

    // reset in cycle 7, then a len=4 job
    run_job(5, 6);
    async_reset();
    step();
    run_job(4, 14);

    // back-to-back with start held high
    bus.start = 1'b1;
    bus.len   = A'(4);
    repeat (26) step();
    bus.start = 1'b0;
    repeat (12) step();

    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.len   = A'($urandom_range(0, 12));
      if ($urandom_range(0, 149) == 0) async_reset();
      else step();
    end
    bus.start = 1'b0;
    repeat (25) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
